vx_sau_unit: RTL and testbench
==============================

Name: vx_sau_unit

Overview:
- Execution stage that consumes the SAU request bundle issued by the dispatcher.
- Processes the thread vector LANES threads per cycle using a sequencing FSM.
- Holds the finished result in an output register until the commit stage accepts it.
- Sits between dispatch (sau_req) and the writeback arbiter (sau_commit).

Parameters:
NUM_THREADS, `NUM_THREADS, threads per warp; must be a multiple of LANES
LANES, 2, threads computed per cycle; 1 <= LANES <= NUM_THREADS
BEATS, NUM_THREADS/LANES (derived, localparam), compute cycles per request

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_uuid  in  `UUID_BITS  instruction id
req_wid  in  `NW_BITS  warp id
req_tmask  in  NUM_THREADS  active-thread mask
req_PC  in  32  instruction PC
req_op_type  in  `INST_FPU_BITS  operation select
req_op_mod  in  `INST_MOD_BITS  modifier; bit0 = saturate
req_rs1_data  in  NUM_THREADS*32  operand A per thread
req_rs2_data  in  NUM_THREADS*32  operand B per thread
req_rd  in  `NR_BITS  destination register
req_wb  in  1  writeback enable
req_ready  out  1  request accepted when valid&ready
commit_valid  out  1  result valid
commit_uuid, commit_wid, commit_tmask, commit_PC, commit_rd, commit_wb  out  same widths as req_*  captured request fields
commit_data  out  NUM_THREADS*32  per-thread result
commit_eop  out  1  end of packet, always 1 when commit_valid
commit_ready  in  1  downstream accept

Behaviour:
- States: IDLE, EXEC, DONE.
- Reset (asynchronous, active-low, takes effect immediately):
  - state=IDLE, beat counter=0.
  - commit_valid=0; all commit_* fields and commit_data = 0.
  - req_ready=1 once reset deasserts.
- Handshake: req_ready = (state==IDLE), registered-state decode, no combinational path from commit_ready.
- IDLE:
  - On req_valid&req_ready, capture all req_* fields and operands, clear result register, beat=0, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - Each cycle compute threads [beat*LANES +: LANES] into the result register, then beat++.
  - When beat==BEATS-1 that cycle, go to DONE and set commit_valid=1 on the next edge.
  - Latency: acceptance edge to commit_valid = BEATS+1 cycles (BEATS=2 -> 3 cycles).
- DONE:
  - commit_valid=1; all commit_* outputs stable while commit_ready=0.
  - On commit_ready=1, commit_valid=0 and state=IDLE on the next edge.
  - The next request can be accepted one cycle after commit (no same-cycle overlap).
  - Throughput: one request per BEATS+2 cycles with commit_ready tied high.
- Operations (op_type), all 32-bit per thread:
  - 0 ADD: A+B, wrapping.
  - 1 SUB: A-B, wrapping.
  - 2 MIN: signed minimum.
  - 3 MAX: signed maximum.
  - 4 ABSDIFF: |A-B| signed, computed in 33 bits, result low 32 bits.
  - Other codes: pass A through.
- Saturate (op_mod[0]=1, ADD/SUB only): signed saturation to 0x7FFFFFFF / 0x80000000 on overflow. Ignored for other ops.
- Thread mask: threads with tmask bit=0 produce commit_data=0. commit_tmask echoes the captured mask. tmask=0 still runs the full sequence and commits.
- wb=0: the request still executes and commits, with commit_wb=0.
- Input changes after acceptance have no effect, since operands are captured.
- If reset asserts mid-EXEC or mid-DONE, the in-flight request is discarded and no commit is produced.

Test Plan:
- NUM_THREADS=4, LANES=2: ADD with A={1,2,3,4}, B={10,20,30,40}, tmask=1111, accepted at cycle 0 -> commit_valid at cycle 3, data={11,22,33,44}, eop=1.
- SUB saturate: A=0x80000000, B=1, op_mod=1 -> 0x80000000; same with op_mod=0 -> 0x7FFFFFFF. ADD saturate: 0x7FFFFFFF+1 -> 0x7FFFFFFF.
- MIN/MAX/ABSDIFF with A=0xFFFFFFFF(-1), B=5 -> MIN=0xFFFFFFFF, MAX=5, ABSDIFF=6. tmask=0101 -> threads 1 and 3 read 0.
- Backpressure: hold commit_ready=0 for 5 cycles -> commit_* stable and req_ready=0 throughout. Raise commit_ready -> one transfer, req_ready=1 on the following cycle. A second req_valid held during stall is accepted only then.
- Reset mid-EXEC: assert reset one cycle after acceptance -> commit_valid=0 immediately and never pulses. After deassert, a new request completes normally with correct uuid/wid/rd echo.
- Random back-to-back requests with random commit_ready against a reference model -> every accepted uuid commits exactly once, in order, with matching data.

Source files
------------

// File: rtl/vx_sau_unit.sv
// SAU execution stage: captures a dispatched request, computes LANES threads per
// beat under a small sequencing FSM, and holds the result until commit accepts it.
module vx_sau_unit #(
    parameter int NUM_THREADS   = 4,
    parameter int LANES         = 2,
    parameter int UUID_BITS     = 44,
    parameter int NW_BITS       = 2,
    parameter int INST_FPU_BITS = 4,
    parameter int INST_MOD_BITS = 3,
    parameter int NR_BITS       = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic [UUID_BITS-1:0]          req_uuid,
    input  logic [NW_BITS-1:0]            req_wid,
    input  logic [NUM_THREADS-1:0]        req_tmask,
    input  logic [31:0]                   req_PC,
    input  logic [INST_FPU_BITS-1:0]      req_op_type,
    input  logic [INST_MOD_BITS-1:0]      req_op_mod,
    input  logic [NUM_THREADS*32-1:0]     req_rs1_data,
    input  logic [NUM_THREADS*32-1:0]     req_rs2_data,
    input  logic [NR_BITS-1:0]            req_rd,
    input  logic                          req_wb,
    output logic                          req_ready,
    output logic                          commit_valid,
    output logic [UUID_BITS-1:0]          commit_uuid,
    output logic [NW_BITS-1:0]            commit_wid,
    output logic [NUM_THREADS-1:0]        commit_tmask,
    output logic [31:0]                   commit_PC,
    output logic [NR_BITS-1:0]            commit_rd,
    output logic                          commit_wb,
    output logic [NUM_THREADS*32-1:0]     commit_data,
    output logic                          commit_eop,
    input  logic                          commit_ready
);

    localparam int          BEATS = NUM_THREADS / LANES;
    localparam int          BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int          DW    = NUM_THREADS * 32;
    localparam int unsigned LW    = LANES * 32;
    localparam int unsigned LN_U  = LANES;

    localparam logic [INST_FPU_BITS-1:0] OP_ADD     = INST_FPU_BITS'(0);
    localparam logic [INST_FPU_BITS-1:0] OP_SUB     = INST_FPU_BITS'(1);
    localparam logic [INST_FPU_BITS-1:0] OP_MIN     = INST_FPU_BITS'(2);
    localparam logic [INST_FPU_BITS-1:0] OP_MAX     = INST_FPU_BITS'(3);
    localparam logic [INST_FPU_BITS-1:0] OP_ABSDIFF = INST_FPU_BITS'(4);
    localparam logic [LW-1:0]            LANE_ONES  = '1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            beat_q;
    logic [INST_FPU_BITS-1:0] op_q;
    logic                     sat_q;
    logic [DW-1:0]            a_q, b_q, res_q;
    logic                     accept, last_beat;
    logic [31:0]              shamt;
    logic [DW-1:0]            a_win, b_win;
    logic [NUM_THREADS-1:0]   m_win;
    logic [LW-1:0]            lane_res;
    logic                     unused_mod_bits;

    // Only the saturate bit of the modifier is meaningful here.
    assign unused_mod_bits = ^req_op_mod;

    assign accept    = req_valid & req_ready;
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign shamt     = 32'(beat_q) * LW;

    function automatic logic [31:0] sau_op(input logic [INST_FPU_BITS-1:0] op,
                                           input logic sat,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] sum, diff, sat_val;
        logic [32:0] d33;
        logic        ovf_add, ovf_sub;
        sum     = a + b;
        diff    = a - b;
        d33     = {a[31], a} - {b[31], b};
        ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);
        ovf_sub = (a[31] != b[31]) && (diff[31] != a[31]);
        sat_val = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        case (op)
            OP_ADD:     return (sat && ovf_add) ? sat_val : sum;
            OP_SUB:     return (sat && ovf_sub) ? sat_val : diff;
            OP_MIN:     return ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:     return ($signed(a) > $signed(b)) ? a : b;
            OP_ABSDIFF: return d33[32] ? (32'd0 - d33[31:0]) : d33[31:0];
            default:    return a;
        endcase
    endfunction

    // Shift the current beat's threads down to lane 0 so lane indexing stays constant.
    always_comb begin
        a_win    = a_q >> shamt;
        b_win    = b_q >> shamt;
        m_win    = commit_tmask >> (32'(beat_q) * LN_U);
        lane_res = '0;
        for (int unsigned l = 0; l < LN_U; l++) begin
            lane_res[l*32 +: 32] = m_win[l] ?
                sau_op(op_q, sat_q, a_win[l*32 +: 32], b_win[l*32 +: 32]) : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid)    state_d = EXEC;
            EXEC:    if (last_beat)    state_d = DONE;
            DONE:    if (commit_ready) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state_q == IDLE);
        commit_valid = (state_q == DONE);
        commit_eop   = commit_valid;
        commit_data  = res_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q       <= '0;
            op_q         <= '0;
            sat_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            commit_uuid  <= '0;
            commit_wid   <= '0;
            commit_tmask <= '0;
            commit_PC    <= '0;
            commit_rd    <= '0;
            commit_wb    <= 1'b0;
        end else if (accept) begin
            beat_q       <= '0;
            op_q         <= req_op_type;
            sat_q        <= req_op_mod[0];
            a_q          <= req_rs1_data;
            b_q          <= req_rs2_data;
            res_q        <= '0;
            commit_uuid  <= req_uuid;
            commit_wid   <= req_wid;
            commit_tmask <= req_tmask;
            commit_PC    <= req_PC;
            commit_rd    <= req_rd;
            commit_wb    <= req_wb;
        end else if (state_q == EXEC) begin
            res_q  <= (res_q & ~(DW'(LANE_ONES) << shamt)) | (DW'(lane_res) << shamt);
            beat_q <= last_beat ? '0 : beat_q + BW'(1);
        end
    end

endmodule

// File: tb/tb_vx_sau_unit.sv
// Directed and randomised checks for vx_sau_unit with 4 threads, 2 lanes.
module tb_vx_sau_unit;

    localparam int NT = 4;
    localparam int DW = NT * 32;
    localparam int UB = 44;
    localparam int N_RND = 40;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            req_valid;
    logic [UB-1:0]   req_uuid;
    logic [1:0]      req_wid;
    logic [NT-1:0]   req_tmask;
    logic [31:0]     req_PC;
    logic [3:0]      req_op_type;
    logic [2:0]      req_op_mod;
    logic [DW-1:0]   req_rs1_data, req_rs2_data;
    logic [4:0]      req_rd;
    logic            req_wb;
    logic            req_ready;
    logic            commit_valid;
    logic [UB-1:0]   commit_uuid;
    logic [1:0]      commit_wid;
    logic [NT-1:0]   commit_tmask;
    logic [31:0]     commit_PC;
    logic [4:0]      commit_rd;
    logic            commit_wb;
    logic [DW-1:0]   commit_data;
    logic            commit_eop;
    logic            commit_ready;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [UB-1:0] uuid;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    vx_sau_unit #(
        .NUM_THREADS(NT), .LANES(2), .UUID_BITS(UB), .NW_BITS(2),
        .INST_FPU_BITS(4), .INST_MOD_BITS(3), .NR_BITS(5)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_uuid(req_uuid), .req_wid(req_wid),
        .req_tmask(req_tmask), .req_PC(req_PC), .req_op_type(req_op_type),
        .req_op_mod(req_op_mod), .req_rs1_data(req_rs1_data),
        .req_rs2_data(req_rs2_data), .req_rd(req_rd), .req_wb(req_wb),
        .req_ready(req_ready),
        .commit_valid(commit_valid), .commit_uuid(commit_uuid),
        .commit_wid(commit_wid), .commit_tmask(commit_tmask),
        .commit_PC(commit_PC), .commit_rd(commit_rd), .commit_wb(commit_wb),
        .commit_data(commit_data), .commit_eop(commit_eop),
        .commit_ready(commit_ready)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pk(input logic [31:0] t3, input logic [31:0] t2,
                                        input logic [31:0] t1, input logic [31:0] t0);
        return {t3, t2, t1, t0};
    endfunction

    // Independent reference: 64-bit signed arithmetic with explicit clamping.
    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic sat,
                                           input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0, 4'd1: begin
                r = (op == 4'd0) ? sa + sb : sa - sb;
                if (sat && r > 64'sd2147483647)  r = 64'sd2147483647;
                if (sat && r < -64'sd2147483648) r = -64'sd2147483648;
                return r[31:0];
            end
            4'd2: return (sa < sb) ? a : b;
            4'd3: return (sa > sb) ? a : b;
            4'd4: begin
                r = sa - sb;
                if (r < 0) r = -r;
                return r[31:0];
            end
            default: return a;
        endcase
    endfunction

    task automatic handshake();
        int n = 0;
        req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_timeout", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_commit();
        int n = 0;
        while (!commit_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("commit_timeout", commit_valid, 1);
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op, input logic [2:0] md,
                           input logic [3:0] mask, input logic [127:0] a,
                           input logic [127:0] b, input logic [127:0] exp);
        req_uuid     = req_uuid + 1;
        req_op_type  = op;
        req_op_mod   = md;
        req_tmask    = mask;
        req_rs1_data = a;
        req_rs2_data = b;
        commit_ready = 1'b1;
        handshake();
        wait_commit();
        check({tag, "_data"}, commit_data, exp);
        check({tag, "_tmask"}, commit_tmask, mask);
        check({tag, "_uuid"}, commit_uuid, req_uuid);
        @(negedge clk);
    endtask

    initial begin
        req_valid = 0; req_uuid = '0; req_wid = '0; req_tmask = '0; req_PC = '0;
        req_op_type = '0; req_op_mod = '0; req_rs1_data = '0; req_rs2_data = '0;
        req_rd = '0; req_wb = 1'b1; commit_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_commit_data", commit_data, 0);
        check("rst_commit_uuid", commit_uuid, 0);
        check("rst_commit_pc", commit_PC, 0);
        check("rst_commit_tmask", commit_tmask, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);

        // Latency: handshake in cycle 0, commit_valid visible in cycle 3.
        req_uuid = 44'h0A5; req_wid = 2'd2; req_PC = 32'h1000; req_rd = 5'd7; req_wb = 1'b1;
        req_op_type = 4'd0; req_op_mod = 3'd0; req_tmask = 4'hF;
        req_rs1_data = pk(4, 3, 2, 1);
        req_rs2_data = pk(40, 30, 20, 10);
        commit_ready = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_rs1_data = pk(32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD);
        check("lat_c1_valid", commit_valid, 0);
        check("lat_c1_ready", req_ready, 0);
        @(negedge clk);
        check("lat_c2_valid", commit_valid, 0);
        @(negedge clk);
        check("lat_c3_valid", commit_valid, 1);
        check("add_data", commit_data, pk(44, 33, 22, 11));
        check("add_eop", commit_eop, 1);
        check("add_uuid", commit_uuid, 44'h0A5);
        check("add_wid", commit_wid, 2);
        check("add_pc", commit_PC, 32'h1000);
        check("add_rd", commit_rd, 7);
        check("add_wb", commit_wb, 1);
        check("add_tmask", commit_tmask, 4'hF);
        @(negedge clk);
        check("lat_c4_valid", commit_valid, 0);
        check("lat_c4_ready", req_ready, 1);

        run_vec("sub_sat", 4'd1, 3'd1, 4'hF,
                pk(0, 32'h7FFFFFFF, 5, 32'h80000000), pk(0, 32'hFFFFFFFF, 3, 1),
                pk(0, 32'h7FFFFFFF, 2, 32'h80000000));
        run_vec("sub_wrap", 4'd1, 3'd0, 4'hF,
                pk(0, 32'h7FFFFFFF, 5, 32'h80000000), pk(0, 32'hFFFFFFFF, 3, 1),
                pk(0, 32'h80000000, 2, 32'h7FFFFFFF));
        run_vec("add_sat", 4'd0, 3'd1, 4'hF,
                pk(32'hFFFFFFFF, 1, 32'h80000000, 32'h7FFFFFFF), pk(1, 2, 32'hFFFFFFFF, 1),
                pk(0, 3, 32'h80000000, 32'h7FFFFFFF));
        run_vec("add_wrap", 4'd0, 3'd0, 4'hF,
                pk(32'hFFFFFFFF, 1, 32'h80000000, 32'h7FFFFFFF), pk(1, 2, 32'hFFFFFFFF, 1),
                pk(0, 3, 32'h7FFFFFFF, 32'h80000000));
        run_vec("min_mask", 4'd2, 3'd0, 4'h5,
                pk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), pk(5, 5, 5, 5),
                pk(0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF));
        run_vec("max_mask", 4'd3, 3'd1, 4'h5,
                pk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), pk(5, 5, 5, 5),
                pk(0, 5, 0, 5));
        run_vec("absd_mask", 4'd4, 3'd0, 4'h5,
                pk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), pk(5, 5, 5, 5),
                pk(0, 6, 0, 6));
        run_vec("absd_edge", 4'd4, 3'd1, 4'hF,
                pk(0, 32'hFFFFFFFF, 3, 32'h7FFFFFFF), pk(0, 5, 10, 32'h80000000),
                pk(0, 6, 7, 32'hFFFFFFFF));
        run_vec("pass_a", 4'd7, 3'd0, 4'hF,
                pk(4, 3, 2, 1), pk(40, 30, 20, 10), pk(4, 3, 2, 1));
        run_vec("mask_zero", 4'd0, 3'd0, 4'h0,
                pk(4, 3, 2, 1), pk(40, 30, 20, 10), 128'd0);

        req_wb = 1'b0;
        run_vec("wb_off", 4'd0, 3'd0, 4'h3, pk(4, 3, 2, 1), pk(1, 1, 1, 1), pk(0, 0, 3, 2));
        req_wb = 1'b1;

        // Backpressure with a second request waiting behind the stalled one.
        commit_ready = 1'b0;
        req_uuid = 44'h100; req_op_type = 4'd0; req_op_mod = 3'd0; req_tmask = 4'hF;
        req_rs1_data = pk(4, 3, 2, 1); req_rs2_data = pk(40, 30, 20, 10);
        handshake();
        wait_commit();
        req_uuid = 44'h200; req_op_type = 4'd1;
        req_rs1_data = pk(100, 100, 100, 100); req_rs2_data = pk(1, 2, 3, 4);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", commit_valid, 1);
            check("bp_uuid", commit_uuid, 44'h100);
            check("bp_data", commit_data, pk(44, 33, 22, 11));
            check("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        commit_ready = 1'b1;
        @(negedge clk);
        check("bp_released_valid", commit_valid, 0);
        check("bp_released_ready", req_ready, 1);
        @(negedge clk);
        check("bp_second_taken", req_ready, 0);
        req_valid = 1'b0;
        wait_commit();
        check("bp_second_uuid", commit_uuid, 44'h200);
        check("bp_second_data", commit_data, pk(99, 98, 97, 96));
        @(negedge clk);

        // Reset one cycle after acceptance discards the request.
        req_uuid = 44'h300;
        handshake();
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("rstx_valid_now", commit_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstx_valid_held", commit_valid, 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstx_no_pulse", commit_valid, 0);
        end
        req_uuid = 44'h400; req_wid = 2'd3; req_rd = 5'd17; req_op_type = 4'd0;
        req_tmask = 4'hF; req_rs1_data = pk(4, 3, 2, 1); req_rs2_data = pk(40, 30, 20, 10);
        handshake();
        wait_commit();
        check("rstx_uuid", commit_uuid, 44'h400);
        check("rstx_wid", commit_wid, 3);
        check("rstx_rd", commit_rd, 17);
        check("rstx_data", commit_data, pk(44, 33, 22, 11));
        @(negedge clk);

        // Random stream against the reference model with random backpressure.
        fork
            begin
                for (int i = 0; i < N_RND; i++) begin
                    exp_t e;
                    logic [31:0] pool [5];
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    req_uuid    = 44'h1000 + 44'(i);
                    req_op_type = 4'($urandom_range(0, 5));
                    req_op_mod  = 3'($urandom_range(0, 7));
                    req_tmask   = 4'($urandom_range(0, 15));
                    for (int t = 0; t < NT; t++) begin
                        pool[0] = $urandom; pool[1] = 32'h7FFFFFFF; pool[2] = 32'h80000000;
                        pool[3] = 32'hFFFFFFFF; pool[4] = 32'd1;
                        req_rs1_data[t*32 +: 32] = pool[$urandom_range(0, 4)];
                        req_rs2_data[t*32 +: 32] = pool[$urandom_range(0, 4)];
                        e.data[t*32 +: 32] = req_tmask[t] ?
                            ref_op(req_op_type, req_op_mod[0], req_rs1_data[t*32 +: 32],
                                   req_rs2_data[t*32 +: 32]) : 32'd0;
                    end
                    e.uuid = req_uuid;
                    handshake();
                    exp_q.push_back(e);
                end
            end
            begin
                int got = 0;
                int cyc = 0;
                while (got < N_RND && cyc < 4000) begin
                    commit_ready = 1'($urandom_range(0, 1));
                    if (commit_valid && commit_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rnd_unexpected_commit", commit_uuid, 0);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check("rnd_uuid", commit_uuid, e.uuid);
                            check("rnd_data", commit_data, e.data);
                        end
                        got++;
                    end
                    @(negedge clk);
                    cyc++;
                end
                check("rnd_commit_count", got, N_RND);
            end
        join
        check("rnd_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
